// File: rtl/decode_stream.sv
// Bit-stream aligner feeding the LZS decode controller: keeps FIFO words
// MSB-first in a shift buffer and presents the next WIN_W unconsumed bits.
module decode_stream #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned WIN_W = 13,
  parameter int unsigned BUF_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_decode,
  input  logic             all_end,
  input  logic [IN_W-1:0]  fi_data,
  input  logic             fi_empty,
  input  logic             fi_done,
  output logic             fi_rd,
  output logic [WIN_W-1:0] stream_data,
  output logic             stream_valid,
  input  logic [3:0]       stream_width,
  input  logic             stream_ack,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(BUF_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [BUF_W-1:0] shift_buf;
  logic [CNT_W-1:0] cnt;

  logic             ack_ok;
  logic             ack_bad;
  logic [CNT_W-1:0] w_eff;
  logic [CNT_W-1:0] cnt_left;
  logic [CNT_W-1:0] cnt_nxt;
  logic [BUF_W-1:0] buf_nxt;
  logic [BUF_W-1:0] refill;

  assign stream_data  = shift_buf[BUF_W-1 -: WIN_W];
  assign stream_valid = ((state == RUN)   && (cnt >= CNT_W'(WIN_W))) ||
                        ((state == DRAIN) && (cnt != '0));

  // all_end wins over refill, so remaining words stay in the FIFO for its owner.
  assign fi_rd = (state == RUN) && !fi_empty && !all_end && (cnt <= CNT_W'(IN_W));

  // In the drain tail a width beyond the valid count would consume padding.
  assign ack_ok  = stream_ack && stream_valid && (stream_width <= 4'(WIN_W)) &&
                   ((state != DRAIN) || (CNT_W'(stream_width) <= cnt));
  assign ack_bad = stream_ack && !ack_ok;

  assign w_eff    = ack_ok ? CNT_W'(stream_width) : '0;
  assign cnt_left = cnt - w_eff;

  // The new word lands directly behind the bits still unconsumed after this cycle.
  assign refill  = {fi_data, {(BUF_W-IN_W){1'b0}}} >> cnt_left;
  assign buf_nxt = fi_rd ? ((shift_buf << w_eff) | refill) : (shift_buf << w_eff);
  assign cnt_nxt = fi_rd ? (cnt_left + CNT_W'(IN_W)) : cnt_left;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_buf <= '0;
      cnt       <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ce_decode) begin
            state     <= RUN;
            shift_buf <= '0;
            cnt       <= '0;
            err       <= 1'b0;
          end else if (ack_bad) begin
            err <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (all_end) begin
            state     <= IDLE;
            shift_buf <= '0;
            cnt       <= '0;
          end else begin
            shift_buf <= buf_nxt;
            cnt       <= cnt_nxt;
            if (ack_bad) err <= 1'b1;
            if ((state == RUN) && fi_empty && fi_done && (cnt_nxt < CNT_W'(WIN_W)))
              state <= DRAIN;
            else if ((state == DRAIN) && (cnt_nxt == '0))
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/decode_stream.md
Name: decode_stream

Overview:
- Bit-stream aligner directly upstream of the LZS decode controller.
- Pops 32-bit compressed words from the input FIFO and keeps them MSB-first in a 64-bit shift buffer.
- Presents the next 13 unconsumed bits as a window, and discards the number of bits the controller reports consumed on each acknowledge.
- Handles start, zero-padded drain at end of input, and flush on end-of-stream.

Parameters:
- IN_W, 32, input word width in bits; bit IN_W-1 is first in the stream.
- WIN_W, 13, window width presented to the decoder.
- BUF_W, 64, shift buffer width; must equal 2*IN_W.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- ce_decode  input  1  start pulse/level; leaves IDLE
- all_end  input  1  end-of-stream indication from the decoder; flushes the block
- fi_data  input  IN_W  FIFO head word; first-word-fall-through, valid while !fi_empty
- fi_empty  input  1  FIFO empty
- fi_done  input  1  level: no further words will be written to the FIFO
- fi_rd  output  1  FIFO pop, combinational
- stream_data  output  WIN_W  next unconsumed bits, buf[BUF_W-1 -: WIN_W]
- stream_valid  output  1  window holds valid data (or padded tail)
- stream_width  input  4  bits consumed, range 0..13, sampled only with stream_ack
- stream_ack  input  1  consume stream_width bits this cycle
- err  output  1  sticky protocol error

Behaviour:
- Registers:
  - buf[63:0], left-aligned, zero-filled.
  - cnt[6:0], number of valid bits, 0..64.
  - state, err.
- Reset:
  - State IDLE, buf=0, cnt=0, err=0.
  - Hence stream_data=0, stream_valid=0, fi_rd=0.
- States:
  - IDLE: fi_rd=0, stream_valid=0. ce_decode -> RUN; buf and cnt cleared on entry.
  - RUN:
    - stream_valid = (cnt>=13).
    - fi_rd = !fi_empty && (cnt<=32).
    - fi_empty && fi_done && cnt<13 -> DRAIN.
    - all_end -> IDLE.
  - DRAIN:
    - stream_valid = (cnt>0). Bits beyond cnt read as zero (padding).
    - fi_rd=0.
    - all_end -> IDLE.
    - cnt reaching 0 -> IDLE.
- Consume: a legal ack requires stream_ack && stream_valid && stream_width<=13. For the DRAIN tail, also stream_width<=cnt.
  - On a legal ack: buf <<= stream_width, cnt -= stream_width.
  - stream_width=0 with ack is legal: no change.
- Refill: when fi_rd, the word is inserted at bit position BUF_W-1-(cnt-w), where w is the width consumed in the same cycle (0 if none), and cnt += 32.
  - Simultaneous consume and refill in one cycle is required. Next cnt = cnt - w + 32, never >64, because refill only happens at cnt<=32.
- Latency:
  - A popped word is visible on stream_data the next cycle.
  - First valid window appears 2 cycles after ce_decode, with a non-empty FIFO.
- Sustained rate: one ack per cycle with widths up to 13 never starves while the FIFO has data (worst case is 32 bits in, ≤13 out per cycle).
- Illegal events (ack while !stream_valid, width>13, width>cnt): the ack is ignored (no state change) and err is set. err is cleared only by rst or on entry to RUN.
- all_end takes priority over refill and consume in the same cycle. Buffered and remaining FIFO words are not popped; the FIFO owner flushes them.
- ce_decode is ignored outside IDLE.
- rst mid-operation: immediate return to IDLE, everything cleared; no fi_rd on the following edge.

Test Plan:
- Reset then ce_decode, FIFO holds 0x80000000, 0x12345678 -> fi_rd pulses one cycle; next cycle stream_data=13'h1000, valid=1; second pop follows (cnt=32<=32), giving cnt=64.
- From that state, ack width 9 -> stream_data=13'h0000 (bits 22..10 of word0 = 0), cnt=55; ack width 13 ×3 -> cnt=16, window equals bits 15..3 of 0x12345678 = 13'h0ACF; refill is not triggered until cnt<=32.
- Continuous acks of width 13 with a 4-word FIFO -> every cycle valid, no bubble; concatenated consumed bits equal the 128-bit input exactly.
- fi_done with 20 bits left, ack 13 -> DRAIN, cnt=7, stream_data = the 7 remaining bits followed by 6 zeros, valid=1; ack width 7 -> IDLE.
- ack while stream_valid=0, and ack with width 14 -> err=1, buf/cnt unchanged; next ce_decode clears err.
- all_end asserted in the same cycle as a refill with 2 words still queued -> no pop, next state IDLE, stream_valid=0; assert rst during RUN -> all outputs 0 asynchronously.
